// File: rtl/neuron_sample_gen_if.sv
// Sample stream bus between the generator and the downstream neuron/scorer.
//   x     : sample vector, bit 0 drives x1
//   label : expected neuron output for x (1 iff exactly one bit of x is set)
//   valid : x/label carry a sample
//   ready : consumer takes the sample this cycle
// master = generator side, slave = consumer side.
interface neuron_sample_gen_if #(
  parameter int NUM_IN = 4
);
  logic [NUM_IN-1:0] x;
  logic              label;
  logic              valid;
  logic              ready;

  modport master (output x, label, valid, input ready);
  modport slave  (input x, label, valid, output ready);
endinterface

// File: rtl/neuron_sample_gen.sv
// Stimulus transmitter for the 4-input one-hot detector neuron. Emits input
// vectors plus the expected label over a valid/ready handshake, in one of
// three sweep modes: exhaustive count, walking one-hot, or LFSR pseudo-random.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a sweep (only looked at in IDLE)
//   mode       : 0 exhaustive, 1 walking one-hot, 2 random, 3 same as 0
//   seed       : LFSR seed for mode 2 (0 selects LFSR_SEED_DEF)
//   bus        : sample stream (x, label, valid out; ready in)
//   busy       : sweep in progress
//   done       : one-cycle pulse after the final sample is accepted
//   count      : samples accepted in the current/last sweep, saturating
module neuron_sample_gen #(
  parameter int         NUM_IN        = 4,
  parameter int         RAND_LEN      = 16,
  parameter logic [7:0] LFSR_SEED_DEF = 8'h01
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [7:0]                seed,
  neuron_sample_gen_if.master       bus,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] M_EXH  = 2'd0;
  localparam logic [1:0] M_WALK = 2'd1;
  localparam logic [1:0] M_RAND = 2'd2;

  state_t            state_q, state_d;
  logic [NUM_IN-1:0] x_q, x_d;
  logic [7:0]        lfsr_q, lfsr_d, lfsr_adv, seed_eff;
  logic [7:0]        cnt_q, cnt_d, cnt_inc;
  logic [1:0]        mode_q, mode_d;
  logic              xfer, last;

  assign seed_eff = (seed == 8'h00) ? LFSR_SEED_DEF : seed;
  // x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0
  assign lfsr_adv = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign cnt_inc  = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
  assign xfer     = (state_q == RUN) && bus.ready;

  // Terminal sample of each mode; the transfer of this sample ends the sweep
  always_comb begin
    case (mode_q)
      M_WALK:  last = x_q[NUM_IN-1];
      M_RAND:  last = (cnt_inc == 8'(RAND_LEN));
      default: last = &x_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= M_EXH;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        cnt_d   = '0;
        // reserved mode 3 is folded into exhaustive at capture
        mode_d  = (mode == 2'd3) ? M_EXH : mode;
        case (mode)
          M_WALK: x_d = NUM_IN'(1);
          M_RAND: begin
            lfsr_d = seed_eff;
            x_d    = seed_eff[NUM_IN-1:0];
          end
          default: x_d = '0;
        endcase
      end
      RUN: if (xfer) begin
        cnt_d = cnt_inc;
        if (last) state_d = DONE;
        else begin
          case (mode_q)
            M_WALK: x_d = x_q << 1;
            M_RAND: begin
              lfsr_d = lfsr_adv;
              x_d    = lfsr_adv[NUM_IN-1:0];
            end
            default: x_d = x_q + NUM_IN'(1);
          endcase
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.valid = (state_q == RUN);
  assign bus.x     = x_q;
  assign bus.label = bus.valid && ($countones(x_q) == 1);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign count     = cnt_q;
endmodule

// File: tb/tb_neuron_sample_gen.sv
module tb_neuron_sample_gen;
  localparam int NI = 4;
  localparam int RL = 16;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [1:0] mode;
  logic [7:0] seed;
  logic       busy, done;
  logic [7:0] count;
  int         cmp_cnt = 0;
  int         err_cnt = 0;

  neuron_sample_gen_if #(.NUM_IN(NI)) bus ();

  neuron_sample_gen #(.NUM_IN(NI), .RAND_LEN(RL), .LFSR_SEED_DEF(8'h01)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
    .bus(bus), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected sample list, built straight from the mode rules
  task automatic build_exp(input logic [1:0] md, input logic [7:0] sd, output int q[$]);
    int l;
    q = {};
    case (md)
      2'd1: for (int i = 0; i < NI; i++) q.push_back(1 << i);
      2'd2: begin
        l = (sd == 0) ? 1 : int'(sd);
        for (int i = 0; i < RL; i++) begin
          q.push_back(l % (1 << NI));
          l = ((l << 1) | (((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1)) & 255;
        end
      end
      default: for (int i = 0; i < (1 << NI); i++) q.push_back(i);
    endcase
  endtask

  // rdy_kind: 0 always ready, 1 toggling 1,0,1,0, 2 random
  task automatic do_sweep(input logic [1:0] md, input logic [7:0] sd,
                          input int rdy_kind, input bit poke);
    int q[$];
    int idx = 0, cyc = 0, n, ex;
    bit r;
    build_exp(md, sd, q);
    n = q.size();
    @(negedge clk);
    start = 1'b1; mode = md; seed = sd; bus.ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (idx < n && cyc < 4000) begin
      ex = q[idx];
      chk("valid", bus.valid, 1);
      chk("busy", busy, 1);
      chk("done_run", done, 0);
      chk("x", bus.x, ex);
      chk("label", bus.label, ($countones(ex[NI-1:0]) == 1));
      chk("count_run", count, idx);
      case (rdy_kind)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.ready = r;
      start = (poke && cyc == 3);
      @(negedge clk);
      cyc++;
      if (r) idx++;
    end
    chk("sweep_len", idx, n);
    chk("done_pulse", done, 1);
    chk("valid_done", bus.valid, 0);
    chk("busy_done", busy, 0);
    chk("label_done", bus.label, 0);
    chk("count_final", count, n);
    start = poke;  // start in the DONE cycle must be ignored
    bus.ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    chk("done_once", done, 0);
    chk("valid_idle", bus.valid, 0);
    chk("busy_idle", busy, 0);
    chk("count_hold", count, n);
    @(negedge clk);
    chk("no_restart", bus.valid, 0);
    bus.ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; seed = 8'h00; bus.ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_x", bus.x, 0);
    chk("rst_label", bus.label, 0);
    rst = 1'b0;

    do_sweep(2'd0, 8'h00, 0, 1'b0);   // exhaustive
    do_sweep(2'd1, 8'h00, 1, 1'b0);   // walking one-hot with backpressure
    do_sweep(2'd2, 8'h00, 0, 1'b0);   // random, zero seed -> default seed
    do_sweep(2'd0, 8'h00, 2, 1'b1);   // start pulses mid-sweep and on DONE
    do_sweep(2'd3, 8'h00, 0, 1'b0);   // reserved mode behaves as exhaustive
    for (int k = 0; k < 4; k++)
      do_sweep(2'd2, 8'($urandom_range(0, 255)), 2, 1'b0);
    do_sweep(2'd1, 8'h00, 2, 1'b1);

    // Reset in the middle of an exhaustive sweep
    @(negedge clk);
    start = 1'b1; mode = 2'd0; bus.ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_x", bus.x, 5);
    chk("pre_rst_count", count, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_valid", bus.valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_count", count, 0);
    chk("mrst_x", bus.x, 0);
    chk("mrst_done", done, 0);
    @(negedge clk);
    chk("mrst_no_done", done, 0);
    chk("mrst_idle", bus.valid, 0);
    bus.ready = 1'b0;
    do_sweep(2'd0, 8'h00, 0, 1'b0);   // restart from x=0

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
